// File: rtl/quad_pkg.sv
// quad_pkg: shared phase constants, direction enum and the quadrature
// transition decoder used by quad_decoder.
//   phase_dir(prev, cur) : classifies a {A,B} phase change as none, forward,
//                          reverse, or illegal (both channels moved at once).
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef enum logic [1:0] {
        DIR_NONE    = 2'd0,
        DIR_UP      = 2'd1,
        DIR_DOWN    = 2'd2,
        DIR_ILLEGAL = 2'd3
    } dir_e;

    // Forward order is 00 -> 10 -> 11 -> 01 -> 00; reverse is the mirror.
    function automatic dir_e phase_dir(input logic [1:0] prev, input logic [1:0] cur);
        dir_e d;
        d = DIR_NONE;
        case ({prev, cur})
            {PH_00, PH_10}, {PH_10, PH_11},
            {PH_11, PH_01}, {PH_01, PH_00}: d = DIR_UP;
            {PH_00, PH_01}, {PH_01, PH_11},
            {PH_11, PH_10}, {PH_10, PH_00}: d = DIR_DOWN;
            {PH_00, PH_11}, {PH_11, PH_00},
            {PH_01, PH_10}, {PH_10, PH_01}: d = DIR_ILLEGAL;
            default:                        d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// input_debounce: 2-flop synchronizer followed by a stable-count debouncer
// for one raw encoder channel.
//   clk, rst : clock, asynchronous active-high reset
//   raw_i    : raw channel level, asynchronous to clk
//   deb_o    : debounced level; changes only after DEBOUNCE_CYCLES
//              consecutive synced samples differ from it
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic deb_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: conditions a raw quadrature encoder and keeps a WIDTH-bit
// position for the downstream PWM stage.
//   clk, reset       : clock, asynchronous active-high reset
//   enc_a, enc_b     : raw encoder channels
//   error_clr        : synchronous clear of the sticky error flag
//   value            : registered position (saturating or wrapping)
//   step_up/down     : one-cycle pulse per accepted forward/reverse transition
//   error            : sticky, set when both channels change together
module quad_decoder #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP            = 1,
    parameter int SATURATE        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             error_clr,
    output logic [WIDTH-1:0] value,
    output logic             step_up,
    output logic             step_down,
    output logic             error
);
    import quad_pkg::*;

    localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] MAX_X  = {1'b0, {WIDTH{1'b1}}};

    logic deb_a, deb_b;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .rst(reset), .raw_i(enc_a), .deb_o(deb_a)
    );
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .rst(reset), .raw_i(enc_b), .deb_o(deb_b)
    );

    logic [1:0]       phase;
    logic [1:0]       prev_q;
    logic [WIDTH-1:0] value_q, value_d;
    logic             up_q, up_d, dn_q, dn_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   sum_x, dif_x;
    dir_e             dir;

    assign phase = {deb_a, deb_b};
    assign dir   = phase_dir(prev_q, phase);

    // One extra bit so the carry/borrow shows whether the step overran a limit.
    assign sum_x = {1'b0, value_q} + STEP_X;
    assign dif_x = {1'b0, value_q} - STEP_X;

    always_comb begin
        value_d = value_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        err_d   = err_q;
        if (error_clr) err_d = 1'b0;
        case (dir)
            DIR_UP: begin
                up_d    = 1'b1;
                value_d = (SATURATE != 0 && sum_x > MAX_X) ? {WIDTH{1'b1}} : sum_x[WIDTH-1:0];
            end
            DIR_DOWN: begin
                dn_d    = 1'b1;
                value_d = (SATURATE != 0 && dif_x[WIDTH]) ? '0 : dif_x[WIDTH-1:0];
            end
            DIR_ILLEGAL: err_d = 1'b1;  // set beats a same-cycle clear
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= PH_00;
            value_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= phase;
            value_q <= value_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            err_q   <= err_d;
        end
    end

    assign value     = value_q;
    assign step_up   = up_q;
    assign step_down = dn_q;
    assign error     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enc_a = 1'b0, enc_b = 1'b0, error_clr = 1'b0;
    logic [7:0] val_s, val_w;
    logic       up_s, dn_s, err_s, up_w, dn_w, err_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int v_sat;
        int v_wrap;
        bit up;
        bit dn;
        bit err;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_prev = 2'b00;
    int         m_sat = 0, m_wrap = 0;
    bit         m_err = 0;

    always #5 clk = ~clk;

    quad_decoder #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .STEP(1), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .error_clr(error_clr),
        .value(val_s), .step_up(up_s), .step_down(dn_s), .error(err_s)
    );

    quad_decoder #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .STEP(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .error_clr(error_clr),
        .value(val_w), .step_up(up_w), .step_down(dn_w), .error(err_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk_all(input string tag, input int vs, input int vw,
                           input bit up, input bit dn, input bit err);
        chk({tag, "_val_sat"},  {24'd0, val_s}, vs);
        chk({tag, "_val_wrap"}, {24'd0, val_w}, vw);
        chk({tag, "_up_sat"},   {31'd0, up_s},  {31'd0, up});
        chk({tag, "_dn_sat"},   {31'd0, dn_s},  {31'd0, dn});
        chk({tag, "_up_wrap"},  {31'd0, up_w},  {31'd0, up});
        chk({tag, "_dn_wrap"},  {31'd0, dn_w},  {31'd0, dn});
        chk({tag, "_err_sat"},  {31'd0, err_s}, {31'd0, err});
        chk({tag, "_err_wrap"}, {31'd0, err_w}, {31'd0, err});
    endtask

    // Drive a new phase; result is due 7 rising edges later (capture + 6).
    task automatic move(input string tag, input logic [1:0] ph, input bit clr_at);
        exp_t e;
        @(negedge clk);
        {enc_a, enc_b} = ph;
        e.up = 0; e.dn = 0;
        if (ph == m_prev) begin
        end else if (ph == fwd_of(m_prev)) begin
            e.up   = 1;
            m_sat  = (m_sat + 1 > 255) ? 255 : m_sat + 1;
            m_wrap = (m_wrap + 4) % 256;
        end else if (m_prev == fwd_of(ph)) begin
            e.dn   = 1;
            m_sat  = (m_sat - 1 < 0) ? 0 : m_sat - 1;
            m_wrap = (m_wrap + 256 - 4) % 256;
        end else begin
            m_err = 1;
        end
        if (clr_at && !(ph != m_prev && ph != fwd_of(m_prev) && m_prev != fwd_of(ph)))
            m_err = 0;
        m_prev  = ph;
        e.v_sat = m_sat; e.v_wrap = m_wrap; e.err = m_err;
        sb.push_back(e);
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_early_up"}, {30'd0, up_s, up_w}, 32'd0);
        chk({tag, "_early_dn"}, {30'd0, dn_s, dn_w}, 32'd0);
        if (clr_at) error_clr = 1'b1;
        @(posedge clk);
        #1;
        error_clr = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk_all(tag, e.v_sat, e.v_wrap, e.up, e.dn, e.err);
        end
        @(posedge clk);
        #1;
        chk({tag, "_pulse_width"}, {28'd0, up_s, up_w, dn_s, dn_w}, 32'd0);
    endtask

    task automatic fwd(input string tag);
        move(tag, fwd_of(m_prev), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        enc_a = 1'b0; enc_b = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_prev = 2'b00; m_sat = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic quiet_clear(input string tag);
        @(negedge clk);
        error_clr = 1'b1;
        @(negedge clk);
        error_clr = 1'b0;
        m_err = 0;
        chk({tag, "_err_sat"},  {31'd0, err_s}, 32'd0);
        chk({tag, "_err_wrap"}, {31'd0, err_w}, 32'd0);
    endtask

    initial begin
        int pulses;
        // Reset state
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Forward step with exact latency
        move("fwd1", 2'b10, 1'b0);

        // Glitch on B: high for 3 cycles only
        @(negedge clk);
        enc_b = 1'b1;
        repeat (3) @(negedge clk);
        enc_b = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (up_s || dn_s || up_w || dn_w || err_s) pulses++;
        end
        chk("glitch_pulses", pulses, 0);
        chk("glitch_val", {24'd0, val_s}, m_sat);
        chk("glitch_cnt", {30'd0, dut_sat.u_deb_b.cnt_q}, 32'd0);

        // Preload to 255, then saturate upward
        for (int i = 0; i < 254; i++) fwd("preload");
        chk("preload_val", {24'd0, val_s}, 32'd255);
        fwd("sat_up");

        // From 0: reverse saturates / wraps, forward restores
        do_reset();
        move("sat_dn", 2'b01, 1'b0);
        move("wrap_fwd", 2'b00, 1'b0);

        // Illegal transition and clears
        move("illegal1", 2'b11, 1'b0);
        quiet_clear("clr_quiet");
        move("illegal_clr", 2'b00, 1'b1);

        // Count to 37 with error still set, then async reset between edges
        while (m_sat < 37) fwd("to37");
        chk("pre_rst_val", {24'd0, val_s}, 32'd37);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid_reset", 0, 0, 0, 0, 0);
        do_reset();
        move("post_rst", 2'b10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
